// File: rtl/fme_cost_select.sv
// Fractional-ME cost selector: accumulates per-candidate SAD on top of lambda*R for
// 12 candidates, then walks them one per cycle to find the minimum total cost.
`timescale 1ns/1ps

module fme_cost_select #(
    parameter int DATAWIDTH = 8,
    parameter int SADWIDTH  = 12,
    parameter int ACCWIDTH  = 16,
    parameter int NBLK      = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    start,
    input  logic [12*DATAWIDTH-1:0] lambdar_in,
    input  logic                    sad_valid,
    input  logic [12*SADWIDTH-1:0]  sad_in,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              best_idx,
    output logic [ACCWIDTH-1:0]     best_cost
);

    localparam int NCAND = 12;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SEARCH, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ACCWIDTH-1:0]   acc_q [NCAND];
    logic [ACCWIDTH-1:0]   acc_d [NCAND];
    logic [ACCWIDTH-1:0]   acc_sum [NCAND];
    logic [ACCWIDTH:0]     sum_wide [NCAND];
    logic [7:0]            beat_q, beat_d;
    logic [3:0]            idx_q, idx_d;
    logic [3:0]            cand;
    logic [ACCWIDTH-1:0]   best_cost_r_q, best_cost_r_d;
    logic [3:0]            best_idx_r_q, best_idx_r_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [3:0]            best_idx_q, best_idx_d;
    logic [ACCWIDTH-1:0]   best_cost_q, best_cost_d;

    // Saturating add of the current SAD beat; one extra bit catches the carry-out.
    always_comb begin
        for (int k = 0; k < NCAND; k++) begin
            sum_wide[k] = {1'b0, acc_q[k]} + (ACCWIDTH+1)'(sad_in[k*SADWIDTH +: SADWIDTH]);
            acc_sum[k]  = sum_wide[k][ACCWIDTH] ? {ACCWIDTH{1'b1}} : sum_wide[k][ACCWIDTH-1:0];
        end
    end

    assign cand = idx_q + 4'd1;

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        beat_d        = beat_q;
        idx_d         = idx_q;
        best_cost_r_d = best_cost_r_q;
        best_idx_r_d  = best_idx_r_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        best_idx_d    = best_idx_q;
        best_cost_d   = best_cost_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int k = 0; k < NCAND; k++) begin
                        acc_d[k] = ACCWIDTH'(lambdar_in[k*DATAWIDTH +: DATAWIDTH]);
                    end
                    beat_d  = 8'd0;
                    busy_d  = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (sad_valid) begin
                    acc_d  = acc_sum;
                    beat_d = beat_q + 8'd1;
                    if (beat_q == 8'(NBLK - 1)) begin
                        // The search seeds from the value candidate 0 takes on this same edge.
                        state_d       = S_SEARCH;
                        idx_d         = 4'd0;
                        best_cost_r_d = acc_sum[0];
                        best_idx_r_d  = 4'd0;
                    end
                end
            end
            S_SEARCH: begin
                idx_d = cand;
                if (acc_q[cand] < best_cost_r_q) begin
                    best_cost_r_d = acc_q[cand];
                    best_idx_r_d  = cand;
                end
                if (cand == 4'(NCAND - 1)) begin
                    // Outputs take the final winner so done and best_* appear together.
                    state_d     = S_DONE;
                    best_idx_d  = best_idx_r_d;
                    best_cost_d = best_cost_r_d;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the accumulator array is reset with the rest so an aborted partition leaves no residue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            for (int k = 0; k < NCAND; k++) acc_q[k] <= '0;
            beat_q        <= '0;
            idx_q         <= '0;
            best_cost_r_q <= '0;
            best_idx_r_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            best_idx_q    <= '0;
            best_cost_q   <= '0;
        end else if (enable) begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            beat_q        <= beat_d;
            idx_q         <= idx_d;
            best_cost_r_q <= best_cost_r_d;
            best_idx_r_q  <= best_idx_r_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            best_idx_q    <= best_idx_d;
            best_cost_q   <= best_cost_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign best_idx  = best_idx_q;
    assign best_cost = best_cost_q;

endmodule

// File: tb/tb_fme_cost_select.sv
// Directed bench for fme_cost_select: two instances (NBLK=2 and NBLK=16) share data
// inputs and have separate start strobes.
`timescale 1ns/1ps

module tb_fme_cost_select;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic         start2 = 1'b0;
    logic         start16 = 1'b0;
    logic         sad_valid = 1'b0;
    logic [95:0]  lambdar_in = '0;
    logic [143:0] sad_in = '0;

    logic         busy2, done2, busy16, done16;
    logic [3:0]   idx2, idx16;
    logic [15:0]  cost2, cost16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    fme_cost_select #(.NBLK(2)) dut2 (
        .clock(clock), .reset(reset), .enable(enable), .start(start2),
        .lambdar_in(lambdar_in), .sad_valid(sad_valid), .sad_in(sad_in),
        .busy(busy2), .done(done2), .best_idx(idx2), .best_cost(cost2)
    );

    fme_cost_select #(.NBLK(16)) dut16 (
        .clock(clock), .reset(reset), .enable(enable), .start(start16),
        .lambdar_in(lambdar_in), .sad_valid(sad_valid), .sad_in(sad_in),
        .busy(busy16), .done(done16), .best_idx(idx16), .best_cost(cost16)
    );

    function automatic logic [95:0] lam_all(input int v);
        logic [95:0] r;
        for (int k = 0; k < 12; k++) r[k*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic logic [95:0] lam_ramp();
        logic [95:0] r;
        for (int k = 0; k < 12; k++) r[k*8 +: 8] = 8'(k);
        return r;
    endfunction

    function automatic logic [143:0] sad_all(input int v);
        logic [143:0] r;
        for (int k = 0; k < 12; k++) r[k*12 +: 12] = 12'(v);
        return r;
    endfunction

    // Drives one partition: start at edge 0, sad_valid/enable per edge from the
    // bit patterns, optional extra start at edge restart_at. Cycle n is observed
    // at the falling edge just before rising edge n.
    task automatic run(input int sel, input logic [95:0] lam, input logic [143:0] sad,
                       input logic [63:0] vpat, input logic [63:0] stall_pat,
                       input int restart_at, output int done_cyc, output int busy_cnt,
                       output logic busy_at_done, output logic [3:0] idx,
                       output logic [15:0] cost, output logic done_after);
        logic b, d;
        @(negedge clock);
        lambdar_in = lam;
        sad_in     = sad;
        sad_valid  = vpat[0];
        enable     = 1'b1;
        if (sel == 2) start2 = 1'b1; else start16 = 1'b1;
        done_cyc     = -1;
        busy_cnt     = 0;
        busy_at_done = 1'bx;
        idx          = 'x;
        cost         = 'x;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            start2     = 1'b0;
            start16    = 1'b0;
            lambdar_in = ~lam;
            b = (sel == 2) ? busy2 : busy16;
            d = (sel == 2) ? done2 : done16;
            if (d === 1'b1) begin
                done_cyc     = n;
                busy_at_done = b;
                idx          = (sel == 2) ? idx2 : idx16;
                cost         = (sel == 2) ? cost2 : cost16;
                break;
            end
            if (b === 1'b1) busy_cnt++;
            sad_valid = (n < 64) ? vpat[n] : 1'b0;
            enable    = (n < 64) ? ~stall_pat[n] : 1'b1;
            if (n == restart_at) begin
                if (sel == 2) start2 = 1'b1; else start16 = 1'b1;
            end
        end
        sad_valid = 1'b0;
        enable    = 1'b1;
        @(negedge clock);
        done_after = (sel == 2) ? done2 : done16;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if ({busy2, done2} !== 2'b00) begin n_fail++; $display("FAIL reset_flags2: got %b expected 00", {busy2, done2}); end
        n_checks++; if ({idx2, cost2} !== 20'd0) begin n_fail++; $display("FAIL reset_best2: got idx %0d cost %0d expected 0 0", idx2, cost2); end
        n_checks++; if ({busy16, done16, idx16, cost16} !== 22'd0) begin n_fail++; $display("FAIL reset_dut16: got %h expected 0", {busy16, done16, idx16, cost16}); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int dc, bc; logic bd, da; logic [3:0] ix; logic [15:0] c;
        run(2, lam_ramp(), sad_all(10), 64'b110, 64'd0, -1, dc, bc, bd, ix, c, da);
        n_checks++; if (dc !== 14) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 14", dc); end
        n_checks++; if (bc !== 13) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 13", bc); end
        n_checks++; if (bd !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", bd); end
        n_checks++; if (ix !== 4'd0 || c !== 16'd20) begin n_fail++; $display("FAIL basic_result: got idx %0d cost %0d expected 0 20", ix, c); end
        n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", da); end
        repeat (3) @(negedge clock);
        n_checks++; if (idx2 !== 4'd0 || cost2 !== 16'd20 || busy2 !== 1'b0) begin n_fail++; $display("FAIL basic_hold: got idx %0d cost %0d busy %b expected 0 20 0", idx2, cost2, busy2); end
    endtask

    task automatic test_min_and_tie();
        int dc, bc; logic bd, da; logic [3:0] ix; logic [15:0] c;
        logic [143:0] s;
        s = sad_all(3);
        s[7*12 +: 12] = 12'd1;
        run(2, lam_all(5), s, 64'b110, 64'd0, -1, dc, bc, bd, ix, c, da);
        n_checks++; if (ix !== 4'd7 || c !== 16'd7) begin n_fail++; $display("FAIL min_lane7: got idx %0d cost %0d expected 7 7", ix, c); end
        s = sad_all(3);
        s[3*12 +: 12] = 12'd1;
        s[9*12 +: 12] = 12'd1;
        // Beat coincident with start must not count: done stays at cycle 14.
        run(2, lam_all(5), s, 64'b111, 64'd0, -1, dc, bc, bd, ix, c, da);
        n_checks++; if (ix !== 4'd3 || c !== 16'd7) begin n_fail++; $display("FAIL tie_lower_idx: got idx %0d cost %0d expected 3 7", ix, c); end
        n_checks++; if (dc !== 14) begin n_fail++; $display("FAIL start_beat_ignored: got done cycle %0d expected 14", dc); end
    endtask

    task automatic test_saturation();
        int dc, bc; logic bd, da; logic [3:0] ix; logic [15:0] c;
        logic [143:0] s;
        s = sad_all(4095);
        s[4*12 +: 12] = 12'd0;
        run(16, lam_all(255), s, 64'h1FFFE, 64'd0, -1, dc, bc, bd, ix, c, da);
        n_checks++; if (dc !== 28) begin n_fail++; $display("FAIL sat_done_cycle: got %0d expected 28", dc); end
        n_checks++; if (ix !== 4'd4 || c !== 16'd255) begin n_fail++; $display("FAIL sat_result: got idx %0d cost %0d expected 4 255", ix, c); end
        s = sad_all(4095);
        run(16, lam_all(255), s, 64'h1FFFE, 64'd0, -1, dc, bc, bd, ix, c, da);
        n_checks++; if (ix !== 4'd0 || c !== 16'd65535) begin n_fail++; $display("FAIL sat_clamp: got idx %0d cost %0d expected 0 65535", ix, c); end
    endtask

    task automatic test_bubbles_stall();
        int dc, bc; logic bd, da; logic [3:0] ix; logic [15:0] c;
        // Beats at edges 1 and 4, stray sad_valid during SEARCH, enable low at edges 7..9,
        // a second start at edge 5 while busy.
        run(2, lam_ramp(), sad_all(10), 64'hC12, 64'h380, 5, dc, bc, bd, ix, c, da);
        n_checks++; if (dc !== 19) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected 19", dc); end
        n_checks++; if (bc !== 18) begin n_fail++; $display("FAIL stall_busy_cycles: got %0d expected 18", bc); end
        n_checks++; if (ix !== 4'd0 || c !== 16'd20) begin n_fail++; $display("FAIL stall_result: got idx %0d cost %0d expected 0 20", ix, c); end
        repeat (20) @(negedge clock);
        n_checks++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin n_fail++; $display("FAIL restart_ignored: got busy %b done %b expected 0 0", busy2, done2); end
    endtask

    task automatic test_async_reset();
        int dc, bc; logic bd, da; logic [3:0] ix; logic [15:0] c;
        @(negedge clock);
        lambdar_in = lam_all(200);
        sad_in     = sad_all(100);
        start2     = 1'b1;
        @(negedge clock);
        start2    = 1'b0;
        sad_valid = 1'b1;
        @(negedge clock);
        sad_valid = 1'b0;
        n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL abort_in_accum: got busy %b expected 1", busy2); end
        #1 reset = 1'b0;
        #1;
        n_checks++; if ({busy2, done2} !== 2'b00 || idx2 !== 4'd0 || cost2 !== 16'd0) begin n_fail++; $display("FAIL abort_immediate: got busy %b done %b idx %0d cost %0d expected 0 0 0 0", busy2, done2, idx2, cost2); end
        n_checks++; if (cost16 !== 16'd0) begin n_fail++; $display("FAIL abort_dut16: got cost %0d expected 0", cost16); end
        @(negedge clock);
        reset = 1'b1;
        run(2, lam_ramp(), sad_all(10), 64'b110, 64'd0, -1, dc, bc, bd, ix, c, da);
        n_checks++; if (dc !== 14 || ix !== 4'd0 || c !== 16'd20) begin n_fail++; $display("FAIL post_reset_run: got cycle %0d idx %0d cost %0d expected 14 0 20", dc, ix, c); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_and_tie();
        test_saturation();
        test_bubbles_stall();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
